// File: rtl/tiny_proc_pkg.sv
// tiny_proc_pkg: mode bus encoding and loader state shared by the tiny processor loader
package tiny_proc_pkg;
    typedef enum logic [1:0] {MODE_IDLE, MODE_INSTR, MODE_REG, MODE_RUN} mode_t;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT_MEM, ST_SHIFT, ST_WAIT_ACK, ST_RUN, ST_ERROR} state_t;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: loadable shift register that serialises one word; zeros fill in behind so the line idles low
module piso_shift #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ser_o
);
    logic [DATA_W-1:0] sr_q, sr_d;
    always_comb sr_d = load_i ? data_i : shift_i ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else sr_q <= sr_d;
    end
    assign ser_o = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: fetches an instruction/register image from memory and serialises it into the tiny core,
// then releases the core into RUN; every output comes straight from a flop.
module prog_loader
    import tiny_proc_pkg::*;
#(
    parameter int N_INSTR   = 16,
    parameter int N_REGS    = 16,
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [$clog2(N_INSTR+1)-1:0]      n_instr_i,
    output logic                              mem_rd_o,
    output logic [$clog2(N_INSTR+N_REGS)-1:0] mem_addr_o,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    output logic [1:0]                        mode_out_o,
    output logic                              mosi_out_o,
    input  logic                              done_in_i,
    output logic                              busy_o,
    output logic                              done_out_o,
    output logic                              err_o
);
    localparam int CW = $clog2(N_INSTR + 1);
    localparam int AW = $clog2(N_INSTR + N_REGS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_W + 1);
    state_t state_q, state_d;
    mode_t phase_q, phase_d, mode_q, mode_d;
    logic [AW-1:0] idx_q, idx_d, n_q, n_d, addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] bit_q, bit_d;
    logic rd_q, busy_q, done_q, err_q, go, last;
    assign go   = start_i && (state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
    assign last = phase_q == MODE_INSTR ? idx_q == n_q - AW'(1) : idx_q == AW'(N_REGS - 1);
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        n_d     = n_q;
        tmo_d   = '0;
        bit_d   = '0;
        if (go) begin
            state_d = ST_FETCH;
            n_d     = n_instr_i > CW'(N_INSTR) ? AW'(N_INSTR) : AW'(n_instr_i);
            phase_d = n_instr_i == '0 ? MODE_REG : MODE_INSTR;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_FETCH:    state_d = ST_WAIT_MEM;
                ST_WAIT_MEM: state_d = ST_SHIFT;
                ST_SHIFT: begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_W - 1)) state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (done_in_i) begin
                        state_d = last && phase_q == MODE_REG ? ST_RUN : ST_FETCH;
                        phase_d = last ? MODE_REG : phase_q;
                        idx_d   = last ? '0 : idx_q + AW'(1);
                    end else if (tmo_q == TW'(TIMEOUT - 1)) state_d = ST_ERROR;
                    else tmo_d = tmo_q + TW'(1);
                end
                default: ;
            endcase
        end
        addr_d = state_d == ST_FETCH ? (phase_d == MODE_REG ? AW'(N_INSTR) + idx_d : idx_d) : addr_q;
        // between words of one load the core keeps its mode; a fresh load starts from 00
        mode_d = state_d == ST_WAIT_MEM ? phase_q :
                 state_d == ST_RUN ? MODE_RUN :
                 (state_d inside {ST_SHIFT, ST_WAIT_ACK} || (state_d == ST_FETCH && busy_q)) ? mode_q : MODE_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= MODE_INSTR;
            mode_q  <= MODE_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            tmo_q   <= '0;
            bit_q   <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            bit_q   <= bit_d;
            rd_q    <= state_d == ST_FETCH;
            busy_q  <= state_d inside {ST_FETCH, ST_WAIT_MEM, ST_SHIFT, ST_WAIT_ACK};
            done_q  <= state_d == ST_RUN && state_q != ST_RUN;
            err_q   <= state_d == ST_ERROR;
        end
    end
    piso_shift #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_piso (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == ST_WAIT_MEM),
        .shift_i(state_q == ST_SHIFT),
        .data_i (mem_rdata_i),
        .ser_o  (mosi_out_o)
    );
    assign mem_rd_o   = rd_q;
    assign mem_addr_o = addr_q;
    assign mode_out_o = mode_q;
    assign busy_o     = busy_q;
    assign done_out_o = done_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench; expected words are queued at start and matched as the serial words appear.
module tb_prog_loader;
    typedef struct {logic [31:0] addr; logic [31:0] data; logic [31:0] mode;} exp_t;
    logic clk = 0, rst_n = 0, start = 0, done_in = 0;
    logic [4:0] n_instr = '0, mem_addr;
    logic [7:0] mem_rdata = '0;
    logic [1:0] mode;
    logic mem_rd, mosi, busy, done_out, err;
    logic start12 = 0, ack12 = 1;
    logic [1:0] n12 = '0, addr12, mode12;
    logic [11:0] rdata12 = '0, w12;
    logic rd12, mosi12, busy12, done12, err12;
    logic [7:0] mem [32];
    logic [11:0] mem12 [4];
    exp_t sb[$];
    logic bq[$];
    int cmps = 0, errs = 0, cyc = 0, mon = -1, dly = -1, wcnt = 0, w01 = 0, w10 = 0;
    int ack_mode = 0, stall_word = -1, stall_end = 0, last_fetch = -1, done_cnt = 0;
    logic [7:0] shreg = '0;
    logic [4:0] waddr = '0;
    logic [1:0] wmode = '0;
    always #5 clk = ~clk;
    prog_loader u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .n_instr_i(n_instr), .mem_rd_o(mem_rd),
        .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mode_out_o(mode), .mosi_out_o(mosi),
        .done_in_i(done_in), .busy_o(busy), .done_out_o(done_out), .err_o(err)
    );
    prog_loader #(.N_INSTR(2), .N_REGS(2), .DATA_W(12), .MSB_FIRST(0), .TIMEOUT(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .start_i(start12), .n_instr_i(n12), .mem_rd_o(rd12),
        .mem_addr_o(addr12), .mem_rdata_i(rdata12), .mode_out_o(mode12), .mosi_out_o(mosi12),
        .done_in_i(ack12), .busy_o(busy12), .done_out_o(done12), .err_o(err12)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask
    // one negedge: memory models, ack driver and the word monitor/scoreboard
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rd12) rdata12 = mem12[addr12];
        if (done_out) done_cnt++;
        if (!rst_n) begin
            mon = -1;
            dly = -1;
            done_in = 0;
        end else begin
            done_in = ack_mode == 1 || dly == 0;
            if (dly >= 0) dly--;
            if (mem_rd) begin
                mem_rdata = mem[mem_addr];
                waddr = mem_addr;
                mon = 0;
                if (ack_mode == 1 && last_fetch >= 0) check("word_period", cyc - last_fetch, 11);
                last_fetch = cyc;
            end else if (mon >= 0) begin
                mon++;
                if (mon >= 2) begin
                    shreg = {shreg[6:0], mosi};
                    wmode = mode;
                end
                if (mon == 9) begin
                    mon = -1;
                    if (sb.size() == 0) check("sb_underflow", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("word_addr", waddr, e.addr);
                        check("word_data", shreg, e.data);
                        check("word_mode", wmode, e.mode);
                    end
                    if (wmode == 2'd1) w01++;
                    if (wmode == 2'd2) w10++;
                    if (wcnt == stall_word) stall_end = cyc;
                    else dly = 2;
                    wcnt++;
                end
            end
        end
    endtask
    task automatic load(input int n, input int am, input int stall, input int abort, input bit poke);
        bit hit;
        ack_mode = am;
        stall_word = stall;
        wcnt = 0;
        w01 = 0;
        w10 = 0;
        done_cnt = 0;
        last_fetch = -1;
        for (int i = 0; i < (n > 16 ? 16 : n); i++) sb.push_back('{addr: i, data: mem[i], mode: 1});
        for (int r = 0; r < 16; r++) sb.push_back('{addr: 16 + r, data: mem[16 + r], mode: 2});
        n_instr = 5'(n);
        start = 1;
        tick();
        start = 0;
        n_instr = 5'd3;
        check("start_busy", busy, 1);
        check("start_err", err, 0);
        hit = 0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            start = poke && c == 50;
            tick();
            hit = done_out || err || (abort >= 0 && wcnt == abort && mon == 4);
        end
        start = 0;
        if (!hit) check("load_timeout", 0, 1);
    endtask
    task automatic post(input int exp01);
        check("run_done_pulse", done_out, 1);
        check("run_mode", mode, 3);
        check("run_busy", busy, 0);
        check("run_err", err, 0);
        check("instr_words", w01, exp01);
        check("reg_words", w10, 16);
        check("sb_left", sb.size(), 0);
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("run_hold", mode, 3);
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_mosi"}, mosi, 0);
        check({tag, "_rd"}, mem_rd, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_err"}, err, 0);
    endtask
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        for (int r = 0; r < 16; r++) mem[16 + r] = 8'(8'h80 + r * 7);
        mem12[0] = 12'hA5C;
        mem12[1] = 12'h123;
        mem12[2] = 12'hF0F;
        mem12[3] = 12'h0B4;
        repeat (3) tick();
        check_reset("reset");
        rst_n = 1;
        tick();
        load(16, 0, -1, -1, 0);
        post(16);
        load(0, 0, -1, -1, 0);
        post(0);
        load(16, 0, 3, -1, 0);
        check("tmo_err", err, 1);
        check("tmo_mode", mode, 0);
        check("tmo_busy", busy, 0);
        check("tmo_cycles", cyc - stall_end, 256);
        check("tmo_sb_left", sb.size(), 28);
        sb.delete();
        load(16, 0, -1, -1, 0);
        post(16);
        load(16, 0, -1, 5, 0);
        rst_n = 0;
        tick();
        check_reset("abort");
        check("abort_sb_left", sb.size(), 27);
        sb.delete();
        rst_n = 1;
        tick();
        load(31, 1, -1, -1, 1);
        post(16);
        w12 = mem12[0];
        for (int i = 0; i < 12; i++) bq.push_back(w12[i]);
        n12 = 2'd1;
        start12 = 1;
        tick();
        start12 = 0;
        check("w12_fetch", rd12, 1);
        check("w12_addr0", addr12, 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("w12_bit", mosi12, bq.pop_front());
        end
        tick();
        check("w12_ack_mosi", mosi12, 0);
        check("w12_mode", mode12, 1);
        tick();
        check("w12_next_fetch", rd12, 1);
        check("w12_reg_addr", addr12, 2);
        for (int c = 0; c < 100 && !done12; c++) tick();
        check("w12_run", mode12, 3);
        check("w12_done", done12, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
